// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// Module : img_pkg
// Brief  : Shared definitions for the image-operation sequencer: operation
//          codes, sequencer state encoding, image geometry constants and an
//          op-legality helper.
// Rev    : 1.0  initial release
// ============================================================================
package img_pkg;

  // Engine operation codes as carried on cmd_op / eng_op / done_op
  localparam logic [1:0] OP_MIRROR  = 2'd0;
  localparam logic [1:0] OP_GRAY    = 2'd1;
  localparam logic [1:0] OP_FILTER  = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  // Image geometry
  localparam int IMG_DIM = 64;
  localparam int PIX_W   = 24;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_HOST  = 2'd3
  } seq_state_t;

  // True for codes the engine can execute
  function automatic logic op_is_legal(input logic [1:0] op);
    return (op == OP_MIRROR) || (op == OP_GRAY) || (op == OP_FILTER);
  endfunction

endpackage
`default_nettype wire

// File: rtl/img_op_sequencer_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module : seq_cmd_fifo
// Brief  : Small synchronous FIFO holding queued operation codes.
//          Registered occupancy count drives full/empty. A push while full is
//          refused even when a pop happens in the same cycle. Flush empties
//          the FIFO and overrides any push or pop in that cycle.
// Ports  : clk, rst_n        clock, asynchronous active-low reset
//          i_flush           discard all entries
//          i_push, i_wdata   write request and data
//          i_pop, o_rdata    read request and head-of-queue data
//          o_count           current occupancy (0..DEPTH)
//          o_full, o_empty   occupancy flags
// Rev    : 1.0  initial release
// ============================================================================
module seq_cmd_fifo #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  // Fullness comes from the registered count only, so a same-cycle pop
  // never opens room for a push.
  assign w_do_push = i_push && !w_full && !i_flush;
  assign w_do_pop  = i_pop  && !w_empty && !i_flush;

  // Pointers are PTR_W wide, so wrap modulo DEPTH falls out naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Storage needs no reset: entries are only read when the count says valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule
`default_nettype wire

// File: rtl/img_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : img_op_sequencer
// Brief  : Queues host operation commands, launches one image-engine
//          operation at a time and waits for its completion, and arbitrates
//          the single image-memory port between the engine and the host.
// Config : SEQ_WATCHDOG_EN - when defined, a RUN watchdog aborts an operation
//          after TIMEOUT cycles without eng_done (sets err, flushes the
//          queue, pulses eng_abort). When undefined RUN waits indefinitely
//          and the eng_abort port does not exist.
// Ports  : clk, rst_n                         clock, async active-low reset
//          cmd_valid, cmd_op, cmd_ready       host command queue interface
//          host_req, host_gnt                 host memory-port request/grant
//          host_row/col/we/pix                host memory access
//          eng_start, eng_op, eng_done        engine launch/completion
//          eng_row/col/we/pix                 engine memory access
//          mem_row/col/we/pix                 muxed memory port
//          busy, op_done, done_op, err        status
//          eng_abort (SEQ_WATCHDOG_EN only)   watchdog abort pulse
// Rev    : 1.0  initial release
// ============================================================================
module img_op_sequencer #(
  parameter int          ADDR_W  = $clog2(img_pkg::IMG_DIM),
  parameter int          PIX_W   = img_pkg::PIX_W,
  parameter int          QDEPTH  = 4,
  parameter logic [15:0] TIMEOUT = 16'd20000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  input  logic              host_req,
  output logic              host_gnt,
  input  logic [ADDR_W-1:0] host_row,
  input  logic [ADDR_W-1:0] host_col,
  input  logic              host_we,
  input  logic [PIX_W-1:0]  host_pix,
  output logic              eng_start,
  output logic [1:0]        eng_op,
  input  logic              eng_done,
  input  logic [ADDR_W-1:0] eng_row,
  input  logic [ADDR_W-1:0] eng_col,
  input  logic              eng_we,
  input  logic [PIX_W-1:0]  eng_pix,
  output logic [ADDR_W-1:0] mem_row,
  output logic [ADDR_W-1:0] mem_col,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_pix,
  output logic              busy,
  output logic              op_done,
  output logic [1:0]        done_op,
`ifdef SEQ_WATCHDOG_EN
  output logic              eng_abort,
`endif
  output logic              err
);

  import img_pkg::*;

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  seq_state_t       r_state;
  seq_state_t       w_state_nxt;

  logic             r_alive;      // low only during the first cycle after reset
  logic [1:0]       r_eng_op;
  logic             r_gnt;
  logic             r_op_done;
  logic [1:0]       r_done_op;
  logic             r_err;

  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic [1:0]       w_fifo_head;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;

  logic             w_load_op;
  logic             w_set_err;
  logic             w_finish;
  logic             w_timeout;

  // --------------------------------------------------------------------------
  // Command queue
  // --------------------------------------------------------------------------
  assign cmd_ready = r_alive && !w_fifo_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_flush   = w_timeout;

  seq_cmd_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (2)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata (cmd_op),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // --------------------------------------------------------------------------
  // RUN watchdog
  // --------------------------------------------------------------------------
`ifdef SEQ_WATCHDOG_EN
  logic [15:0] r_wd_cnt;

  // Counter reads 0 in the first RUN cycle, so the abort lands in RUN cycle
  // number TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_START) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  // A completion arriving in the very cycle of expiry still wins.
  assign w_timeout = (r_state == ST_RUN) && !eng_done &&
                     (r_wd_cnt == TIMEOUT - 16'd1);
  assign eng_abort = w_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load_op   = 1'b0;
    w_set_err   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Host access outranks queued work.
        if (host_req) begin
          w_state_nxt = ST_HOST;
        end else if (!w_fifo_empty) begin
          w_pop = 1'b1;
          if (op_is_legal(w_fifo_head)) begin
            w_load_op   = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_set_err = 1'b1;
          end
        end
      end
      ST_START: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (eng_done) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOST: begin
        if (!host_req) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered status / handshake outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive   <= 1'b0;
      r_eng_op  <= 2'd0;
      r_gnt     <= 1'b0;
      r_op_done <= 1'b0;
      r_done_op <= 2'd0;
      r_err     <= 1'b0;
    end else begin
      r_alive   <= 1'b1;
      if (w_load_op) begin
        r_eng_op <= w_fifo_head;
      end
      // Grant trails HOST entry by one cycle and drops the cycle after
      // host_req falls.
      r_gnt     <= (r_state == ST_HOST) && host_req;
      r_op_done <= w_finish;
      if (w_finish) begin
        r_done_op <= r_eng_op;
      end
      if (w_set_err || w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign eng_start = (r_state == ST_START);
  assign eng_op    = r_eng_op;
  assign host_gnt  = r_gnt;
  assign op_done   = r_op_done;
  assign done_op   = r_done_op;
  assign err       = r_err;
  assign busy      = (r_state != ST_IDLE) || (w_fifo_count != '0);

  // --------------------------------------------------------------------------
  // Memory port mux, selected by registered state only
  // --------------------------------------------------------------------------
  always_comb begin
    mem_row = '0;
    mem_col = '0;
    mem_we  = 1'b0;
    mem_pix = '0;
    case (r_state)
      ST_START, ST_RUN: begin
        mem_row = eng_row;
        mem_col = eng_col;
        mem_we  = eng_we;
        mem_pix = eng_pix;
      end
      ST_HOST: begin
        if (r_gnt) begin
          mem_row = host_row;
          mem_col = host_col;
          mem_we  = host_we;
          mem_pix = host_pix;
        end
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire
